// File: rtl/systolic_pkg.sv
// Shared definitions for the 4-PE linear systolic chain and its sequencer.
//   N_PE, DW, AW : array geometry (PE count, data/weight/bias width, accumulator width)
//   seq_state_t  : sequencer FSM state encoding
//   onehot_pe()  : PE index -> one-hot enable vector
package systolic_pkg;

   localparam int unsigned N_PE     = 4;
   localparam int unsigned PE_IDX_W = 2;
   localparam int unsigned DW       = 4;
   localparam int unsigned AW       = 8;

   typedef enum logic [2:0] {
      StIdle,
      StLoadW,
      StLoadB,
      StStream,
      StFlush,
      StDrain
   } seq_state_t;

   function automatic logic [N_PE-1:0] onehot_pe(input logic [PE_IDX_W-1:0] idx);
      logic [N_PE-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/systolic_skew_sr.sv
// Enable/valid skew shift register for a linear systolic chain.
// Bit 0 takes shift_in each cycle and bit i takes bit i-1, so bit i is the
// entry valid delayed by i cycles, matching PE i's one-cycle-per-hop data delay.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (priority over shifting)
//   shift_in : value entering bit 0
//   q        : current register contents
module systolic_skew_sr #(
   parameter int unsigned Width = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_in,
   output logic [Width-1:0] q
);

   logic [Width-1:0] sr_q;
   logic [Width-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (clr) begin
         sr_d = '0;
      end else begin
         sr_d = {sr_q[Width-2:0], shift_in};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign q = sr_q;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the 4-PE linear systolic chain.
// Loads 4 weights then 4 biases from the parameter stream onto the shared
// buses with one-hot enables, streams num_samples inputs into PE0 with
// skewed accumulate enables, then drains the 4 accumulators as a
// valid/ready result stream.
//   clk, rst                         : clock, synchronous active-high reset
//   start, num_samples               : job launch (sampled in idle only)
//   busy, done                       : job status, done is a one-cycle pulse
//   p_valid/p_ready/p_data           : parameter stream
//   x_valid/x_ready/x_data           : sample stream
//   res_valid/res_ready/res_data/idx : result stream
//   arr_*, pe_*_en, drain_sel        : registered array-side controls
//   arr_acc_out                      : selected accumulator from the array
module systolic_seq_ctrl
   import systolic_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [CNT_W-1:0]    num_samples,
   output logic                busy,
   output logic                done,
   input  logic                p_valid,
   output logic                p_ready,
   input  logic [DW-1:0]       p_data,
   input  logic                x_valid,
   output logic                x_ready,
   input  logic [DW-1:0]       x_data,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [AW-1:0]       res_data,
   output logic [PE_IDX_W-1:0] res_idx,
   output logic [DW-1:0]       arr_data_in,
   output logic [DW-1:0]       arr_weight_in,
   output logic [DW-1:0]       arr_bias_in,
   output logic [N_PE-1:0]     pe_weight_en,
   output logic [N_PE-1:0]     pe_bias_en,
   output logic [N_PE-1:0]     pe_acc_en,
   output logic [PE_IDX_W-1:0] drain_sel,
   input  logic [AW-1:0]       arr_acc_out
);

   seq_state_t          state_q, state_d;
   logic [2:0]          beat_q, beat_d;
   logic [CNT_W-1:0]    smp_q, smp_d;
   logic [CNT_W-1:0]    num_q, num_d;
   logic [DW-1:0]       data_q, data_d;
   logic [DW-1:0]       wdata_q, wdata_d;
   logic [DW-1:0]       bdata_q, bdata_d;
   logic [N_PE-1:0]     wen_q, wen_d;
   logic [N_PE-1:0]     ben_q, ben_d;
   logic [PE_IDX_W-1:0] drain_sel_q, drain_sel_d;
   logic                done_q, done_d;

   logic                p_acc;
   logic                x_acc;
   logic                r_hs;
   logic                sr_clr;
   logic [N_PE-1:0]     acc_en;

   // Handshake-facing outputs depend on state only, so they never combine
   // with the upstream valids.
   always_comb begin
      busy      = (state_q != StIdle);
      p_ready   = (state_q == StLoadW) || (state_q == StLoadB);
      x_ready   = (state_q == StStream);
      res_valid = (state_q == StDrain);
      p_acc     = p_valid & p_ready;
      x_acc     = x_valid & x_ready;
      r_hs      = res_valid & res_ready;
   end

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      smp_d       = smp_q;
      num_d       = num_q;
      wdata_d     = wdata_q;
      bdata_d     = bdata_q;
      wen_d       = '0;
      ben_d       = '0;
      drain_sel_d = drain_sel_q;
      done_d      = 1'b0;
      sr_clr      = 1'b0;
      // Bubbles put zero on the data bus; the matching enable bit is low anyway.
      data_d      = x_acc ? x_data : '0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               num_d       = num_samples;
               beat_d      = '0;
               smp_d       = '0;
               drain_sel_d = '0;
               sr_clr      = 1'b1;
               state_d     = StLoadW;
            end
         end
         StLoadW: begin
            if (p_acc) begin
               wdata_d = p_data;
               wen_d   = onehot_pe(beat_q[PE_IDX_W-1:0]);
               beat_d  = beat_q + 3'd1;
               if (beat_q == 3'd3) begin
                  state_d = StLoadB;
               end
            end
         end
         StLoadB: begin
            if (p_acc) begin
               bdata_d = p_data;
               ben_d   = onehot_pe(beat_q[PE_IDX_W-1:0]);
               beat_d  = beat_q + 3'd1;
               if (beat_q == 3'd7) begin
                  state_d = (num_q == '0) ? StFlush : StStream;
               end
            end
         end
         StStream: begin
            if (x_acc) begin
               smp_d = smp_q + CNT_W'(1);
               if (smp_d == num_q) begin
                  state_d = StFlush;
               end
            end
         end
         StFlush: begin
            // Wait until the last sample's enable has walked off PE3.
            if (acc_en == '0) begin
               drain_sel_d = '0;
               state_d     = StDrain;
            end
         end
         StDrain: begin
            if (r_hs) begin
               if (drain_sel_q == PE_IDX_W'(N_PE - 1)) begin
                  drain_sel_d = '0;
                  done_d      = 1'b1;
                  state_d     = StIdle;
               end else begin
                  drain_sel_d = drain_sel_q + PE_IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         beat_q      <= '0;
         smp_q       <= '0;
         num_q       <= '0;
         data_q      <= '0;
         wdata_q     <= '0;
         bdata_q     <= '0;
         wen_q       <= '0;
         ben_q       <= '0;
         drain_sel_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         smp_q       <= smp_d;
         num_q       <= num_d;
         data_q      <= data_d;
         wdata_q     <= wdata_d;
         bdata_q     <= bdata_d;
         wen_q       <= wen_d;
         ben_q       <= ben_d;
         drain_sel_q <= drain_sel_d;
         done_q      <= done_d;
      end
   end

   systolic_skew_sr #(
      .Width(N_PE)
   ) u_skew_sr (
      .clk      (clk),
      .rst      (rst),
      .clr      (sr_clr),
      .shift_in (x_acc),
      .q        (acc_en)
   );

   assign done          = done_q;
   assign arr_data_in   = data_q;
   assign arr_weight_in = wdata_q;
   assign arr_bias_in   = bdata_q;
   assign pe_weight_en  = wen_q;
   assign pe_bias_en    = ben_q;
   assign pe_acc_en     = acc_en;
   assign drain_sel     = drain_sel_q;
   assign res_idx       = drain_sel_q;
   assign res_data      = arr_acc_out;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with a behavioural 4-PE chain model.
module tb_systolic_seq_ctrl;
   import systolic_pkg::*;

   localparam int unsigned CNT_W = 8;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic [CNT_W-1:0]    num_samples = '0;
   logic                busy, done;
   logic                p_valid = 1'b0;
   logic                p_ready;
   logic [DW-1:0]       p_data = '0;
   logic                x_valid = 1'b0;
   logic                x_ready;
   logic [DW-1:0]       x_data = '0;
   logic                res_valid;
   logic                res_ready = 1'b0;
   logic [AW-1:0]       res_data;
   logic [PE_IDX_W-1:0] res_idx;
   logic [DW-1:0]       arr_data_in, arr_weight_in, arr_bias_in;
   logic [N_PE-1:0]     pe_weight_en, pe_bias_en, pe_acc_en;
   logic [PE_IDX_W-1:0] drain_sel;
   logic [AW-1:0]       arr_acc_out;

   int n_tests = 0;
   int n_fail  = 0;

   systolic_seq_ctrl #(
      .CNT_W(CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .num_samples   (num_samples),
      .busy          (busy),
      .done          (done),
      .p_valid       (p_valid),
      .p_ready       (p_ready),
      .p_data        (p_data),
      .x_valid       (x_valid),
      .x_ready       (x_ready),
      .x_data        (x_data),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_data      (res_data),
      .res_idx       (res_idx),
      .arr_data_in   (arr_data_in),
      .arr_weight_in (arr_weight_in),
      .arr_bias_in   (arr_bias_in),
      .pe_weight_en  (pe_weight_en),
      .pe_bias_en    (pe_bias_en),
      .pe_acc_en     (pe_acc_en),
      .drain_sel     (drain_sel),
      .arr_acc_out   (arr_acc_out)
   );

   always #5 clk = ~clk;

   // Behavioural PE chain: each PE registers its data_out, so PE i sees
   // arr_data_in delayed by i cycles.
   logic [DW-1:0] m_w    [N_PE];
   logic [AW-1:0] m_acc  [N_PE];
   logic [DW-1:0] m_pipe [N_PE];
   logic [DW-1:0] m_din  [N_PE];

   always_comb begin
      m_din[0] = arr_data_in;
      for (int i = 1; i < N_PE; i++) m_din[i] = m_pipe[i-1];
   end

   always @(posedge clk) begin
      for (int i = 0; i < N_PE; i++) begin
         m_pipe[i] <= m_din[i];
         if (pe_weight_en[i]) m_w[i] <= arr_weight_in;
         if (pe_bias_en[i]) m_acc[i] <= AW'(arr_bias_in);
         else if (pe_acc_en[i]) m_acc[i] <= m_acc[i] + AW'(m_din[i]) * AW'(m_w[i]);
      end
   end

   assign arr_acc_out = m_acc[drain_sel];

   // Monitors sample on the falling edge.
   logic [N_PE-1:0]   acc_log [$];
   logic [2*N_PE-1:0] en_log  [$];
   int                done_cnt = 0;

   always @(negedge clk) begin
      if (busy === 1'b1) acc_log.push_back(pe_acc_en);
      if ((pe_weight_en | pe_bias_en) != '0) en_log.push_back({pe_weight_en, pe_bias_en});
      if (done === 1'b1) done_cnt++;
   end

   logic [DW-1:0]       w_tab [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
   logic [DW-1:0]       b_tab [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
   logic [DW-1:0]       x_tab [4] = '{4'd2, 4'd3, 4'd0, 4'd0};
   logic [AW-1:0]       got_d   [$];
   logic [PE_IDX_W-1:0] got_i   [$];
   logic [AW-1:0]       stall_d [$];
   logic [PE_IDX_W-1:0] stall_i [$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      acc_log.delete();
      en_log.delete();
      done_cnt = 0;
   endtask

   function automatic int first_nz();
      for (int i = 0; i < acc_log.size(); i++) if (acc_log[i] != '0) return i;
      return -1;
   endfunction

   function automatic int count_nz();
      int c = 0;
      for (int i = 0; i < acc_log.size(); i++) if (acc_log[i] != '0) c++;
      return c;
   endfunction

   task automatic start_job(input int ns);
      start       = 1'b1;
      num_samples = CNT_W'(ns);
      step();
      start       = 1'b0;
   endtask

   task automatic load_params();
      for (int k = 0; k < 8; k++) begin
         int g = 0;
         p_valid = 1'b1;
         p_data  = (k < 4) ? w_tab[k] : b_tab[k-4];
         while (!p_ready && g < 20) begin
            step();
            g++;
         end
         n_tests++;
         if (g >= 20) begin
            $display("FAIL param_wait: beat %0d never accepted, p_ready=%b expected 1", k, p_ready);
            n_fail++;
         end
         step();
      end
      p_valid = 1'b0;
   endtask

   task automatic stream(input int ns, input logic [7:0] vpat);
      int idx = 0;
      int g   = 0;
      while (idx < ns && g < 64) begin
         x_valid = (g < 8) ? vpat[g] : 1'b1;
         x_data  = x_valid ? x_tab[idx] : 4'hF;
         if (x_valid && x_ready) idx++;
         step();
         g++;
      end
      x_valid = 1'b0;
      x_data  = '0;
      n_tests++;
      if (idx != ns) begin
         $display("FAIL stream_timeout: accepted %0d samples, expected %0d", idx, ns);
         n_fail++;
      end
   endtask

   task automatic drain_results(input int stall_at, input int stall_len);
      int n       = 0;
      int g       = 0;
      int stalled = 0;
      got_d.delete();
      got_i.delete();
      stall_d.delete();
      stall_i.delete();
      while (n < 4 && g < 100) begin
         if (res_valid) begin
            if (n == stall_at && stalled < stall_len) begin
               res_ready = 1'b0;
               stall_d.push_back(res_data);
               stall_i.push_back(res_idx);
               stalled++;
            end else begin
               res_ready = 1'b1;
               got_d.push_back(res_data);
               got_i.push_back(res_idx);
               n++;
            end
         end else begin
            res_ready = 1'b0;
         end
         step();
         g++;
      end
      res_ready = 1'b0;
      n_tests++;
      if (n != 4) begin
         $display("FAIL drain_timeout: got %0d results, expected 4", n);
         n_fail++;
      end
      repeat (3) step();
   endtask

   task automatic test_reset();
      n_tests++;
      if ({busy, done, p_ready, x_ready, res_valid} !== 5'b0) begin
         $display("FAIL por_status: got %b expected 00000", {busy, done, p_ready, x_ready, res_valid});
         n_fail++;
      end
      start_job(2);
      load_params();
      x_valid = 1'b1;
      x_data  = x_tab[0];
      step();
      x_valid = 1'b0;
      n_tests++;
      if ({busy, x_ready, pe_acc_en, arr_data_in} !== {1'b1, 1'b1, 4'b0001, x_tab[0]}) begin
         $display("FAIL mid_stream: got busy=%b x_ready=%b acc_en=%b data=%0d expected 1 1 0001 %0d",
                  busy, x_ready, pe_acc_en, arr_data_in, x_tab[0]);
         n_fail++;
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++;
      if ({busy, done, p_ready, x_ready, res_valid} !== 5'b0) begin
         $display("FAIL rst_status: got %b expected 00000", {busy, done, p_ready, x_ready, res_valid});
         n_fail++;
      end
      n_tests++;
      if ({arr_data_in, arr_weight_in, arr_bias_in} !== '0) begin
         $display("FAIL rst_buses: got %h expected 000", {arr_data_in, arr_weight_in, arr_bias_in});
         n_fail++;
      end
      n_tests++;
      if ({pe_weight_en, pe_bias_en, pe_acc_en, drain_sel} !== '0) begin
         $display("FAIL rst_enables: got %h expected 0", {pe_weight_en, pe_bias_en, pe_acc_en, drain_sel});
         n_fail++;
      end
      step();
      n_tests++;
      if ({busy, pe_acc_en} !== 5'b0) begin
         $display("FAIL rst_idle_hold: got %b expected 00000", {busy, pe_acc_en});
         n_fail++;
      end
   endtask

   task automatic check_results(input string tag, input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                                input logic [AW-1:0] e2, input logic [AW-1:0] e3);
      logic [AW-1:0] exp_d [4];
      exp_d = '{e0, e1, e2, e3};
      n_tests++;
      if (got_d.size() != 4 || done_cnt != 1 || busy !== 1'b0) begin
         $display("FAIL %s_end: got results=%0d done=%0d busy=%b expected 4 1 0",
                  tag, got_d.size(), done_cnt, busy);
         n_fail++;
      end
      for (int i = 0; i < 4 && i < got_d.size(); i++) begin
         n_tests++;
         if (got_d[i] !== exp_d[i] || got_i[i] !== PE_IDX_W'(i)) begin
            $display("FAIL %s_res%0d: got data=%0d idx=%0d expected data=%0d idx=%0d",
                     tag, i, got_d[i], got_i[i], exp_d[i], i);
            n_fail++;
         end
      end
   endtask

   task automatic test_nominal();
      logic [3:0] pat [5];
      int f;
      pat = '{4'h1, 4'h3, 4'h6, 4'hC, 4'h8};
      clear_logs();
      start_job(2);
      load_params();
      stream(2, 8'hFF);
      drain_results(-1, 0);
      check_results("nominal", 8'd5, 8'd11, 8'd17, 8'd23);
      f = first_nz();
      n_tests++;
      if (f < 0 || count_nz() != 5 || f + 5 > acc_log.size()) begin
         $display("FAIL nominal_acc_count: got %0d active cycles expected 5", count_nz());
         n_fail++;
      end else begin
         for (int j = 0; j < 5; j++) begin
            n_tests++;
            if (acc_log[f+j] !== pat[j]) begin
               $display("FAIL nominal_acc_en%0d: got %b expected %b", j, acc_log[f+j], pat[j]);
               n_fail++;
            end
         end
      end
   endtask

   task automatic test_bubbles();
      logic [3:0] pat [7];
      int f;
      pat = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h2, 4'h4, 4'h8};
      clear_logs();
      start_job(2);
      load_params();
      stream(2, 8'b1111_1001);
      drain_results(-1, 0);
      check_results("bubble", 8'd5, 8'd11, 8'd17, 8'd23);
      f = first_nz();
      n_tests++;
      if (f < 0 || count_nz() != 7 || f + 7 > acc_log.size()) begin
         $display("FAIL bubble_acc_count: got %0d active cycles expected 7", count_nz());
         n_fail++;
      end else begin
         for (int j = 0; j < 7; j++) begin
            n_tests++;
            if (acc_log[f+j] !== pat[j]) begin
               $display("FAIL bubble_acc_en%0d: got %b expected %b", j, acc_log[f+j], pat[j]);
               n_fail++;
            end
         end
      end
   endtask

   task automatic test_zero_samples();
      clear_logs();
      start_job(0);
      load_params();
      drain_results(-1, 0);
      check_results("zero", 8'd0, 8'd1, 8'd2, 8'd3);
      n_tests++;
      if (count_nz() != 0) begin
         $display("FAIL zero_acc_en: got %0d active cycles expected 0", count_nz());
         n_fail++;
      end
   endtask

   task automatic test_backpressure();
      clear_logs();
      start_job(2);
      load_params();
      stream(2, 8'hFF);
      drain_results(2, 5);
      check_results("bp", 8'd5, 8'd11, 8'd17, 8'd23);
      n_tests++;
      if (stall_d.size() != 5) begin
         $display("FAIL bp_stall_len: got %0d stalled cycles expected 5", stall_d.size());
         n_fail++;
      end
      for (int i = 0; i < stall_d.size(); i++) begin
         n_tests++;
         if (stall_d[i] !== 8'd17 || stall_i[i] !== 2'd2) begin
            $display("FAIL bp_hold%0d: got data=%0d idx=%0d expected data=17 idx=2", i, stall_d[i], stall_i[i]);
            n_fail++;
         end
      end
   endtask

   task automatic test_protocol();
      logic [7:0] pat [8];
      int acc_cnt = 0;
      pat = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08};
      clear_logs();
      start       = 1'b1;
      num_samples = CNT_W'(2);
      step();
      // start stays high through the whole parameter phase
      for (int k = 0; k < 10; k++) begin
         p_valid = 1'b1;
         p_data  = (k < 4) ? w_tab[k] : ((k < 8) ? b_tab[k-4] : 4'h7);
         if (p_ready) acc_cnt++;
         step();
      end
      p_valid = 1'b0;
      start   = 1'b0;
      n_tests++;
      if (acc_cnt != 8) begin
         $display("FAIL proto_p_accepts: got %0d expected 8", acc_cnt);
         n_fail++;
      end
      n_tests++;
      if ({busy, x_ready} !== 2'b11) begin
         $display("FAIL proto_state: got busy/x_ready=%b expected 11", {busy, x_ready});
         n_fail++;
      end
      n_tests++;
      if (en_log.size() != 8) begin
         $display("FAIL proto_en_count: got %0d expected 8", en_log.size());
         n_fail++;
      end
      for (int i = 0; i < 8 && i < en_log.size(); i++) begin
         n_tests++;
         if (en_log[i] !== pat[i]) begin
            $display("FAIL proto_en%0d: got w/b=%b expected %b", i, en_log[i], pat[i]);
            n_fail++;
         end
      end
      stream(2, 8'hFF);
      // Extra samples offered after the last one must be refused.
      for (int k = 0; k < 3; k++) begin
         x_valid = 1'b1;
         x_data  = 4'hF;
         n_tests++;
         if (x_ready !== 1'b0) begin
            $display("FAIL proto_extra_x%0d: got x_ready=%b expected 0", k, x_ready);
            n_fail++;
         end
         step();
      end
      x_valid = 1'b0;
      drain_results(-1, 0);
      check_results("proto", 8'd5, 8'd11, 8'd17, 8'd23);
   endtask

   initial begin
      repeat (2) step();
      rst = 1'b0;
      test_reset();
      test_nominal();
      test_bubbles();
      test_zero_samples();
      test_backpressure();
      test_protocol();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for the 4-PE linear systolic chain.
- Accepts a parameter stream carrying 4 weights then 4 biases, and loads each into its PE over the shared weight/bias buses using one-hot enables.
- Streams N input samples into PE0 and generates per-PE accumulate enables skewed to match the chain's data delay, including bubbles. Then drains the 4 accumulators through drain_sel as a valid/ready result stream.
- Sits between the host/IO shim and the array top level.

Parameters:
N_PE, 4, number of PEs; fixed at 4 to match the 2-bit drain_sel.
DW, 4, data/weight/bias width.
AW, 8, accumulator width.
CNT_W, 8, sample-count width.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin a job; sampled only in IDLE
num_samples  in  CNT_W  samples per job; latched when start is accepted
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse after the last result handshake
p_valid / p_ready / p_data  in/out/in  1/1/DW  parameter stream (4 weights, then 4 biases)
x_valid / x_ready / x_data  in/out/in  1/1/DW  sample stream
res_valid / res_ready / res_data / res_idx  out/in/out/out  1/1/AW/2  result stream
arr_data_in  out  DW  to PE0 data_in
arr_weight_in  out  DW  shared weight bus
arr_bias_in  out  DW  shared bias bus
pe_weight_en  out  N_PE  one-hot weight write
pe_bias_en  out  N_PE  one-hot bias write
pe_acc_en  out  N_PE  per-PE accumulate enable
drain_sel  out  2  selects which accumulator is on arr_acc_out
arr_acc_out  in  AW  selected accumulator from the array

Behaviour:
- Reset (rst=1 at a clk edge) applies from any state, including mid-job:
  - state goes to IDLE; counters and the acc shift register clear.
  - All array-side outputs go to 0: arr_*, pe_*_en, drain_sel.
  - busy, done, res_valid, p_ready and x_ready go to 0.
  - The PEs are not otherwise reset by this block.
- Array contract:
  - PE i sees arr_data_in delayed by i cycles (each PE registers data_out).
  - A PE writes on the edge where its enable is high.
  - A bias write re-initialises that PE's accumulator to the bias value.
  - An accumulate does acc += data_in * weight, modulo 2^AW.
- All array-side outputs are registered. A handshake in cycle t produces the PE write at the end of cycle t+1.
- States: IDLE, LOAD_W, LOAD_B, STREAM, FLUSH, DRAIN.
- IDLE:
  - On start=1: latch num_samples, clear the counters, go to LOAD_W.
  - start in any other state is ignored.
- LOAD_W:
  - p_ready=1.
  - Accept k (0..3): next cycle drives arr_weight_in=p_data and pe_weight_en=1<<k.
  - After the 4th accept, go to LOAD_B.
- LOAD_B:
  - Same as LOAD_W, using arr_bias_in and pe_bias_en.
  - After the 4th accept: if num_samples==0 go to FLUSH, else go to STREAM.
- STREAM:
  - x_ready=1.
  - Shift register v[3:0] updates every cycle: v[0] <= accept (x_valid & x_ready); v[i] <= v[i-1].
  - pe_acc_en = v.
  - arr_data_in <= accept ? x_data : 0.
  - A bubble (x_valid=0) propagates as a gap in the skewed enables.
  - The sample counter increments on each accept. On the num_samples-th accept, go to FLUSH.
- FLUSH:
  - x_ready=0; v keeps shifting in zeros.
  - When v==0, set drain_sel to 0 and go to DRAIN.
  - This gives 4 cycles after the last accept; when num_samples==0 it exits the cycle after entry.
- DRAIN:
  - res_valid=1, res_idx=drain_sel, res_data=arr_acc_out (combinational passthrough).
  - While res_ready=0, res_data and res_idx hold stable.
  - On handshake with drain_sel<3: drain_sel increments.
  - On handshake with drain_sel==3: done pulses in the next cycle, state returns to IDLE, drain_sel returns to 0.
- A p_valid that arrives after the 8 parameter beats is not accepted (p_ready=0).
- Extra samples beyond num_samples are not accepted (x_ready=0).
- Counter widths: parameter beat counter 3 bits, sample counter CNT_W bits. No wrap is possible within a single job.

Decomposition:
- Shared package systolic_pkg holds:
  - N_PE, DW, AW
  - the state enum seq_state_t
  - the function onehot_pe(idx) that returns an N_PE-bit one-hot.
- One sub-module, systolic_skew_sr: the N_PE-bit enable/valid shift register with synchronous clear. It is reusable for wider arrays.

Test Plan:
1. Reset: assert rst mid-STREAM -> next cycle all outputs 0, busy=0, state IDLE. A following start runs a clean job.
2. Nominal job: weights 1,2,3,4; biases 0,1,2,3; samples 2,3 (num_samples=2) -> results idx0..3 = 5,11,17,23. pe_acc_en patterns 0001, 0011, 0110, 1100, 1000. done pulses once.
3. Bubbles: same job with x_valid pattern 1,0,0,1 -> identical results. pe_acc_en[i] equals pe_acc_en[0] delayed by i cycles.
4. num_samples=0: same weights/biases -> results 0,1,2,3. pe_acc_en never asserted.
5. Backpressure: res_ready low for 5 cycles at idx2 -> res_data=17 and res_idx=2 held stable, no skipped or duplicated idx.
6. Protocol: start asserted while busy is ignored. p_valid held high for 10 beats -> exactly 8 accepted, and the one-hot order of pe_weight_en then pe_bias_en is 0001, 0010, 0100, 1000.
